// File: rtl/hamming74_encoder.sv
`default_nettype none
// ============================================================================
// Module      : hamming74_encoder
// Description : Hamming(7,4) single-error-correcting encoder on the transmit
//               side of the datapath. Takes a 4-bit data nibble and produces
//               a 7-bit codeword with even parity. The codeword MSB is code
//               position 1 and the LSB is code position 7:
//                   ham_out = {p1, p2, d3, p4, d2, d1, d0}
//               Data sits at positions 3,5,6,7 and parity at positions 1,2,4.
//               Every codeword therefore has a zero position-indexed syndrome.
//
// Parameters  : REGISTER_OUT - 1: codeword registered, 1-cycle latency
//                              0: ham_out combinational, out_valid = in_valid
//
// Ports       : clk        in   1  clock, rising edge (unused when REGISTER_OUT=0)
//               rst        in   1  asynchronous active-high reset (unused when REGISTER_OUT=0)
//               in_valid   in   1  data_in holds a nibble to encode this cycle
//               data_in    in   4  data nibble d[3:0]
//               out_valid  out  1  ham_out holds a valid codeword
//               ham_out    out  7  codeword {p1,p2,d3,p4,d2,d1,d0}
//
// Revision    : 1.0 - initial release
// ============================================================================
module hamming74_encoder #(
    parameter int REGISTER_OUT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] data_in,
    output logic       out_valid,
    output logic [6:0] ham_out
);

    // Each parity bit covers the data positions whose index has the
    // corresponding bit set: p1 -> 3,5,7 ; p2 -> 3,6,7 ; p4 -> 5,6,7.
    // With d3@3, d2@5, d1@6, d0@7 this gives the equations below.
    logic w_p1;
    logic w_p2;
    logic w_p4;
    logic [6:0] w_code;

    assign w_p1   = data_in[3] ^ data_in[2] ^ data_in[0];
    assign w_p2   = data_in[3] ^ data_in[1] ^ data_in[0];
    assign w_p4   = data_in[2] ^ data_in[1] ^ data_in[0];
    assign w_code = {w_p1, w_p2, data_in[3], w_p4, data_in[2], data_in[1], data_in[0]};

    generate
        if (REGISTER_OUT != 0) begin : g_reg
            logic [6:0] r_ham;
            logic       r_valid;

            // The codeword register only loads on valid input, so idle-cycle
            // garbage (including X) on data_in never reaches ham_out.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ham   <= 7'b000_0000;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= in_valid;
                    if (in_valid) begin
                        r_ham <= w_code;
                    end
                end
            end

            assign ham_out   = r_ham;
            assign out_valid = r_valid;
        end else begin : g_comb
            // Clock and reset have no function in this mode; fold them into a
            // dummy net so they are not reported as dangling inputs.
            logic w_unused;
            assign w_unused  = clk ^ rst;

            assign ham_out   = w_code;
            assign out_valid = in_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hamming74_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming74_encoder
// Description : Directed self-checking bench for hamming74_encoder. Covers the
//               registered configuration (reset, directed vectors, back-to-back
//               sweep with syndrome checks, asynchronous mid-stream reset,
//               idle hold) and the combinational configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming74_encoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] data_in;
    logic       out_valid;
    logic [6:0] ham_out;

    logic       c_in_valid;
    logic [3:0] c_data_in;
    logic       c_out_valid;
    logic [6:0] c_ham_out;

    int total;
    int bad;

    // Hand-computed codewords for nibbles 0..15, {p1,p2,d3,p4,d2,d1,d0}.
    logic [6:0] code_tbl [16];

    hamming74_encoder #(.REGISTER_OUT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
        .ham_out   (ham_out)
    );

    hamming74_encoder #(.REGISTER_OUT(0)) dut_comb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (c_in_valid),
        .data_in   (c_data_in),
        .out_valid (c_out_valid),
        .ham_out   (c_ham_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Position-indexed syndrome: XOR of the indices of all set positions,
    // position k living at bit 7-k.
    function automatic logic [2:0] syndrome(input logic [6:0] w);
        logic [2:0] s;
        s = 3'd0;
        for (int k = 1; k <= 7; k++) begin
            if (w[7-k]) s = s ^ 3'(k);
        end
        return s;
    endfunction

    // Drive one cycle at the falling edge, sample 1 time unit after the rise.
    task automatic step(input logic v, input logic [3:0] d);
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] prev;
        logic [6:0] held;

        total = 0;
        bad   = 0;
        code_tbl[0]  = 7'b0000000;  code_tbl[1]  = 7'b1101001;
        code_tbl[2]  = 7'b0101010;  code_tbl[3]  = 7'b1000011;
        code_tbl[4]  = 7'b1001100;  code_tbl[5]  = 7'b0100101;
        code_tbl[6]  = 7'b1100110;  code_tbl[7]  = 7'b0001111;
        code_tbl[8]  = 7'b1110000;  code_tbl[9]  = 7'b0011001;
        code_tbl[10] = 7'b1011010;  code_tbl[11] = 7'b0110011;
        code_tbl[12] = 7'b0111100;  code_tbl[13] = 7'b1010101;
        code_tbl[14] = 7'b0010110;  code_tbl[15] = 7'b1111111;

        rst        = 1'b1;
        in_valid   = 1'b0;
        data_in    = 4'b0000;
        c_in_valid = 1'b0;
        c_data_in  = 4'b0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ham", ham_out, 7'b0000000);
        check("reset_valid", {6'd0, out_valid}, 7'd1 - 7'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        step(1'b1, 4'b0010);
        check("d0010_ham", ham_out, 7'b0101010);
        check("d0010_valid", {6'd0, out_valid}, 7'd1);
        step(1'b1, 4'b0000);
        check("d0000_ham", ham_out, 7'b0000000);
        step(1'b1, 4'b0100);
        check("d0100_ham", ham_out, 7'b1001100);
        step(1'b1, 4'b0001);
        check("d0001_ham", ham_out, 7'b1101001);
        step(1'b1, 4'b1111);
        check("d1111_ham", ham_out, 7'b1111111);

        // Back-to-back sweep with latency, syndrome and single-flip checks
        prev = 7'b1111111;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in  = 4'(i);
            #1;
            check($sformatf("sweep_pre_edge_%0d", i), ham_out, prev);
            @(posedge clk);
            #1;
            check($sformatf("sweep_ham_%0d", i), ham_out, code_tbl[i]);
            check($sformatf("sweep_valid_%0d", i), {6'd0, out_valid}, 7'd1);
            check($sformatf("sweep_syn_%0d", i), {4'd0, syndrome(ham_out)}, 7'd0);
            for (int k = 1; k <= 7; k++) begin
                logic [6:0] flipped;
                flipped = ham_out ^ (7'd1 << (7 - k));
                check($sformatf("flip_syn_%0d_pos%0d", i, k), {4'd0, syndrome(flipped)}, 7'(k));
            end
            prev = code_tbl[i];
        end

        // Asynchronous reset between edges while out_valid is high
        step(1'b1, 4'b1011);
        check("pre_rst_valid", {6'd0, out_valid}, 7'd1);
        check("pre_rst_ham", ham_out, 7'b0110011);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ham", ham_out, 7'b0000000);
        check("async_rst_valid", {6'd0, out_valid}, 7'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 4'b0101);
        check("resume_ham", ham_out, 7'b0100101);
        check("resume_valid", {6'd0, out_valid}, 7'd1);

        // Idle cycles with changing / unknown data hold the last codeword
        held = 7'b0100101;
        step(1'b0, 4'bxxxx);
        check("idle_x_valid", {6'd0, out_valid}, 7'd0);
        check("idle_x_ham", ham_out, held);
        step(1'b0, 4'b1000);
        check("idle_chg_valid", {6'd0, out_valid}, 7'd0);
        check("idle_chg_ham", ham_out, held);
        step(1'b0, 4'b0111);
        check("idle_chg2_ham", ham_out, held);
        step(1'b1, 4'b1000);
        check("after_idle_ham", ham_out, 7'b1110000);

        // Combinational configuration
        for (int i = 0; i < 16; i += 5) begin
            c_in_valid = i[0];
            c_data_in  = 4'(i);
            #1;
            check($sformatf("comb_ham_%0d", i), c_ham_out, code_tbl[i]);
            check($sformatf("comb_valid_%0d", i), {6'd0, c_out_valid}, {6'd0, i[0]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
